// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the MEM-stage SRAM controller: the access state
// enum, the default parameter values and a small state-classification helper.
// No ports (package).
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

  // One state per half-word phase plus the idle and completion states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int DEF_PHASE_CYCLES = 2;
  localparam int DEF_BASE_ADDR    = 1024;
  localparam int DEF_ADDR_W       = 18;

  // True for the states in which the phase counter is running
  function automatic logic in_phase(input state_t s);
    return (s == RD_LO) || (s == RD_HI) || (s == WR_LO) || (s == WR_HI);
  endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// ---------------------------------------------------------------------------
// sram_phase_counter
// Counts 0 .. PHASE_CYCLES-1 inside one half-word phase and flags the last
// count so the controller knows when to advance. The count wraps to zero on
// its last value so consecutive phases start cleanly.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset
//   clear - hold the counter at zero (controller not inside a phase)
//   last  - high on the final cycle of the current phase
// ---------------------------------------------------------------------------
module sram_phase_counter
  import sram_ctrl_pkg::*;
#(
  parameter int PHASE_CYCLES = DEF_PHASE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic last
);

  localparam int CW = $clog2(PHASE_CYCLES);

  logic [CW-1:0] count;

  assign last = (count == CW'(PHASE_CYCLES - 1));

  // Free-running inside a phase, wrapping on the last count; held at zero
  // whenever the controller is idle or completing an access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear || last) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
// Sequences 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM as
// two half-word phases (low half first). While an access is in flight
// `ready` is low; the top level ORs ~ready into the pipeline freeze.
//
// Optional feature: define SRAM_READ_BUFFER_EN to add a single-entry read
// buffer (valid, word-index tag, 32-bit data). A read hitting the buffer
// goes straight from IDLE to DONE.
//
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-low reset
//   rd_en        - load request
//   wr_en        - store request (wins when both enables are high)
//   addr         - byte address; bits [1:0] ignored
//   wdata        - store value
//   rdata        - load result, valid in DONE and held until the next load
//   ready        - high when no access is in flight
//   sram_addr    - SRAM half-word address
//   sram_dq_out  - write data driven to the SRAM
//   sram_dq_oe   - high while the controller drives the data pins
//   sram_dq_in   - read data from the SRAM
//   sram_we_n    - active-low SRAM write strobe
// ---------------------------------------------------------------------------
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int PHASE_CYCLES = DEF_PHASE_CYCLES,
  parameter int BASE_ADDR    = DEF_BASE_ADDR,
  parameter int ADDR_W       = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_we_n
);

  localparam int WIDX_W = ADDR_W - 1;

  state_t            state;
  state_t            next_state;
  logic              phase_last;
  logic              hit;
  logic              start_access;
  logic              hit_done;
  logic [WIDX_W-1:0] req_widx;
  logic [WIDX_W-1:0] widx_q;
  logic              hi_q;
  logic [31:0]       wdata_q;
  logic [15:0]       lo_q;
  logic [31:0]       buf_word;

  // Word index relative to the SRAM window; the byte offset falls out of the
  // shift and the upper bits are truncated to the SRAM word-address width.
  assign req_widx = WIDX_W'((addr - 32'(BASE_ADDR)) >> 2);

  // The half-word select is the address LSB, so it also picks the data lane.
  assign sram_addr   = {widx_q, hi_q};
  assign sram_dq_out = hi_q ? wdata_q[31:16] : wdata_q[15:0];

  assign start_access = (state == IDLE) &&
                        ((next_state == RD_LO) || (next_state == WR_LO));
  assign hit_done     = (state == IDLE) && (next_state == DONE);

  sram_phase_counter #(
    .PHASE_CYCLES(PHASE_CYCLES)
  ) u_phase_counter (
    .clk  (clk),
    .rst  (rst),
    .clear(!in_phase(state)),
    .last (phase_last)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and strobe decode. The write strobe is released on the last
  // cycle of each write phase so address and data stay stable past the
  // rising edge of we_n.
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    sram_dq_oe = 1'b0;
    sram_we_n  = 1'b1;
    unique case (state)
      IDLE: begin
        ready = ~(rd_en | wr_en);
        if (wr_en) begin
          next_state = WR_LO;
        end else if (rd_en) begin
          next_state = hit ? DONE : RD_LO;
        end
      end
      RD_LO: begin
        if (phase_last) next_state = RD_HI;
      end
      RD_HI: begin
        if (phase_last) next_state = DONE;
      end
      WR_LO: begin
        sram_dq_oe = 1'b1;
        sram_we_n  = phase_last;
        if (phase_last) next_state = WR_HI;
      end
      WR_HI: begin
        sram_dq_oe = 1'b1;
        sram_we_n  = phase_last;
        if (phase_last) next_state = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request latch and read assembly. The address and store value are
  // captured as IDLE is left so a dropped request still completes. The low
  // read half is parked until the high half arrives, and rdata changes only
  // when a load enters DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      widx_q  <= '0;
      hi_q    <= 1'b0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata   <= '0;
    end else begin
      if (start_access) begin
        widx_q  <= req_widx;
        wdata_q <= wdata;
        hi_q    <= 1'b0;
      end else if (((state == RD_LO) || (state == WR_LO)) && phase_last) begin
        hi_q <= 1'b1;
      end
      if ((state == RD_LO) && phase_last) begin
        lo_q <= sram_dq_in;
      end
      if ((state == RD_HI) && phase_last) begin
        rdata <= {sram_dq_in, lo_q};
      end else if (hit_done) begin
        rdata <= buf_word;
      end
    end
  end

`ifdef SRAM_READ_BUFFER_EN
  logic              buf_valid;
  logic [WIDX_W-1:0] buf_tag;
  logic [31:0]       buf_data;

  assign hit      = buf_valid && (buf_tag == req_widx);
  assign buf_word = buf_data;

  // Read buffer: a completed SRAM read refills the entry; a store to the
  // buffered word refreshes its data as the store enters DONE so a later
  // hit never returns stale data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if ((state == RD_HI) && phase_last) begin
      buf_valid <= 1'b1;
      buf_tag   <= widx_q;
      buf_data  <= {sram_dq_in, lo_q};
    end else if ((state == WR_HI) && phase_last && buf_valid &&
                 (buf_tag == widx_q)) begin
      buf_data <= wdata_q;
    end
  end
`else
  assign hit      = 1'b0;
  assign buf_word = '0;
`endif

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller that sequences the MEM stage's 32-bit data-memory accesses onto an external 16-bit asynchronous SRAM. Each word is moved as two half-word phases. While an access is in flight the controller holds `ready` low, and the top level uses that as the pipeline freeze. It sits between the MEM pipeline register outputs (address, store value, read/write enables) and the SRAM pins, and its `rdata` replaces the data-memory output into the MEM/WB register.

## Interface
- `PHASE_CYCLES`, default 2: cycles per half-word phase; legal values are 2 or more.
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.
- `ADDR_W`, default 18: SRAM half-word address width.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-low.
- `rd_en` input, 1 bit: load request (MEM_R_EN).
- `wr_en` input, 1 bit: store request (MEM_W_EN).
- `addr` input, 32 bits: byte address (ALU result); bits [1:0] are ignored.
- `wdata` input, 32 bits: store value (Val_Rm).
- `rdata` output, 32 bits: load result; valid in the DONE cycle and held until the next read completes.
- `ready` output, 1 bit: high means no access is in flight; the top level uses the inverse as the pipeline freeze.
- `sram_addr` output, ADDR_W bits: half-word address.
- `sram_dq_out` output, 16 bits: write data driven to the SRAM.
- `sram_dq_oe` output, 1 bit: high while the controller drives the data pins.
- `sram_dq_in` input, 16 bits: read data from the SRAM.
- `sram_we_n` output, 1 bit: active-low SRAM write strobe.

## Operation
- **Word index:** `widx = (addr - BASE_ADDR) >> 2`, truncated to ADDR_W-1 bits.
- **Half-word addresses:** low half is `{widx, 1'b0}` and carries bits [15:0]; high half is `{widx, 1'b1}` and carries bits [31:16]. The low half is always accessed first.
- **States and transitions:**
  - IDLE goes to RD_LO on `rd_en`, or to WR_LO on `wr_en`.
  - RD_LO → RD_HI → DONE.
  - WR_LO → WR_HI → DONE.
  - DONE → IDLE, unconditionally.
- **Phase counter:** counts 0 to PHASE_CYCLES-1 within each phase and advances the state on its last count.
- **Read phase:**
  - `sram_dq_oe` = 0, `sram_we_n` = 1.
  - `sram_dq_in` is captured on the last cycle of the phase.
  - `rdata` updates on entry to DONE.
- **Write phase:**
  - `sram_dq_oe` = 1 and `sram_dq_out` holds the half-word for the whole phase.
  - `sram_we_n` = 0 on every cycle except the last, which gives address and data hold time.
- **`ready` (combinational):** equals `~(rd_en | wr_en)` in IDLE, 1 in DONE, and 0 in every other state.
- **Simultaneous `rd_en` and `wr_en`:** treated as a write.
- **Request latching:** `addr` and `wdata` are latched when IDLE is left. If the request drops mid-access, the access still completes.
- **Reset at any time:**
  - State returns to IDLE and the phase counter to 0.
  - Outputs go to `sram_addr` = 0, `sram_dq_out` = 0, `sram_dq_oe` = 0, `sram_we_n` = 1, `rdata` = 0.
  - `ready` = `~(rd_en | wr_en)`.
  - A partially written word is left in the SRAM as-is.

## Timing
- The request is first seen in cycle 0, with `ready` = 0.
- The phases occupy cycles 1 to 2×PHASE_CYCLES.
- DONE is cycle 2×PHASE_CYCLES+1, with `ready` = 1; the pipeline advances on that edge.
- With the defaults, `ready` is low for 5 cycles and high in cycle 5.
- Back-to-back requests:
  - The next instruction's request is seen in the IDLE cycle that follows DONE.
  - There is one idle cycle between accesses.
  - No request is lost.

## Configuration
- **`SRAM_READ_BUFFER_EN` defined:**
  - A single-entry read buffer holds a valid bit, a word-index tag and 32 bits of data.
  - A read whose index matches the tag, with valid set, goes IDLE → DONE directly, so `ready` is low for 1 cycle only.
  - A read that misses fills the buffer at DONE.
  - A write to a matching index updates the buffer data in the same cycle the write enters DONE.
  - Reset clears the valid bit.
- **`SRAM_READ_BUFFER_EN` undefined:** every read takes the full latency; there is no buffer logic.

## Structure
- Shared package `sram_ctrl_pkg` holds:
  - the state enum (IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE);
  - the default constants for PHASE_CYCLES, BASE_ADDR and ADDR_W.
- One sub-module, `sram_phase_counter`: a counter with clear and an `last` flag, parameterised by PHASE_CYCLES.
- The top level is instantiated in the MEM stage. `~ready` is ORed into the IF/ID/EXE/MEM register freeze inputs.

## Test plan
All scenarios use the default parameters.
- **Write:** `wr_en`=1, `addr`=1028, `wdata`=0xDEADBEEF.
  - `sram_addr`=2 with `dq_out`=0xBEEF, then `sram_addr`=3 with `dq_out`=0xDEAD.
  - `we_n` low in cycles 1 and 3 only.
  - `ready` low in cycles 0–4, high in cycle 5.
- **Read back:** `rd_en`=1, `addr`=1028 against the SRAM model.
  - `rdata`=0xDEADBEEF in cycle 5.
  - `dq_oe`=0 throughout.
- **Read buffer:** with `SRAM_READ_BUFFER_EN`, repeat the read of 1028.
  - `ready` high in cycle 1.
  - `rdata`=0xDEADBEEF.
  - No SRAM address change.
- **Write updates buffer:** with `SRAM_READ_BUFFER_EN`, write 0x12345678 to 1028, then read 1028.
  - Buffer hit, `rdata`=0x12345678.
- **Simultaneous enables:** `rd_en`=`wr_en`=1 → write sequence, `rdata` unchanged.
- **Reset mid-write:** assert `rst`=0 in cycle 2 of a write.
  - Immediately `we_n`=1, `dq_oe`=0, `rdata`=0.
  - After release with no request, `ready`=1.
